// File: rtl/jtpopeye_dwnld.sv
// jtpopeye_dwnld: ROM download write path.
// Turns the ioctl byte stream into byte-masked SDRAM write requests (prog_*)
// and one-cycle video PROM write strobes. Bytes pass through a 2-entry FIFO
// and retire strictly in arrival order.
// Optional build macro: JTPOPEYE_DWNLD_CHKSUM_EN adds the dwn_sum output.
module jtpopeye_dwnld #(
  parameter logic [21:0] PROM_START = 22'h1_C000,
  parameter logic [11:0] PROM_LEN   = 12'h600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        sdram_ack,
  output logic [7:0]  prom_addr,
  output logic [7:0]  prom_din,
  output logic        prom_5n_we,
  output logic        prom_7j_we,
  output logic        prom_4a_we,
  output logic        prom_5b_we,
  output logic        prom_5a_we,
  output logic        prom_3a_we,
  output logic        dwn_busy,
  output logic        dwn_ovf
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
  ,
  output logic [15:0] dwn_sum
`endif
);

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
  } dwn_entry_t;

  typedef enum logic [1:0] { IDLE, SDWR, PROMWR } state_t;

  state_t     state, next_state;
  dwn_entry_t mem [2];
  dwn_entry_t head, in_entry;
  logic       wr_ptr, rd_ptr;
  logic [1:0] cnt;
  logic       dl_q, dl_rise;
  logic       push_req, pop, go_sd, go_prom, sd_done;
  logic       sd_own;
  logic [21:0] diff;
  logic       is_sd, is_prom;
  logic [2:0] slot;
  logic [5:0] prom_we_r;

  assign dl_rise  = downloading & ~dl_q;
  assign push_req = downloading & ioctl_wr;
  assign in_entry = '{addr: ioctl_addr, data: ioctl_data};
  assign head     = mem[rd_ptr];

  // Address decode of the FIFO head
  assign diff    = head.addr - PROM_START;
  assign is_sd   = head.addr < PROM_START;
  assign is_prom = !is_sd && (diff < {10'd0, PROM_LEN});
  assign slot    = diff[10:8];

  assign dwn_busy = (cnt != 2'd0) || (state != IDLE);

  assign {prom_3a_we, prom_5a_we, prom_5b_we, prom_4a_we, prom_7j_we, prom_5n_we} = prom_we_r;

  // Download-start edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dl_q <= 1'b0;
    else        dl_q <= downloading;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and FIFO pop decisions
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    go_sd      = 1'b0;
    go_prom    = 1'b0;
    sd_done    = 1'b0;
    case (state)
      IDLE: if (cnt != 2'd0) begin
        if (is_sd) begin
          next_state = SDWR;
          go_sd      = 1'b1;
        end else if (is_prom) begin
          next_state = PROMWR;
          go_prom    = 1'b1;
          pop        = 1'b1;
        end else begin
          pop = 1'b1;              // out of range: drop silently
        end
      end
      SDWR: if (sdram_ack) begin
        next_state = IDLE;
        sd_done    = 1'b1;
        pop        = sd_own;       // head was flushed by a restart: nothing to pop
      end
      PROMWR: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The in-flight SDRAM write owns the FIFO head until acked, unless a
  // download restart flushed the FIFO underneath it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sd_own <= 1'b0;
    else if (dl_rise) sd_own <= 1'b0;
    else if (go_sd)   sd_own <= 1'b1;
    else if (sd_done) sd_own <= 1'b0;
  end

  // 2-entry FIFO with overflow detection; a restart flushes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      cnt     <= 2'd0;
      dwn_ovf <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (dl_rise) begin
      rd_ptr  <= 1'b0;
      dwn_ovf <= 1'b0;
      if (push_req) begin
        mem[0] <= in_entry;
        wr_ptr <= 1'b1;
        cnt    <= 2'd1;
      end else begin
        wr_ptr <= 1'b0;
        cnt    <= 2'd0;
      end
    end else begin
      if (push_req && (cnt != 2'd2 || pop)) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push_req && cnt == 2'd2 && !pop) dwn_ovf <= 1'b1;
      case ({push_req && (cnt != 2'd2 || pop), pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Registered SDRAM request and PROM write outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
      prog_we   <= 1'b0;
      prom_addr <= '0;
      prom_din  <= '0;
      prom_we_r <= '0;
    end else begin
      prom_we_r <= '0;
      if (go_sd) begin
        prog_addr <= {1'b0, head.addr[21:1]};
        prog_data <= head.data;
        prog_mask <= head.addr[0] ? 2'b01 : 2'b10;
        prog_we   <= 1'b1;
      end
      if (sd_done) begin
        prog_we   <= 1'b0;
        prog_mask <= 2'b11;
      end
      if (go_prom) begin
        prom_addr <= diff[7:0];
        prom_din  <= head.data;
        prom_we_r <= 6'd1 << slot;
      end
    end
  end

`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
  // Running mod-2^16 sum of retired bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dwn_sum <= 16'd0;
    else if (dl_rise) dwn_sum <= 16'd0;
    else if (sd_done) dwn_sum <= dwn_sum + {8'd0, prog_data};
    else if (go_prom) dwn_sum <= dwn_sum + {8'd0, head.data};
  end
`endif

endmodule

// File: doc/jtpopeye_dwnld.md
Name: jtpopeye_dwnld

Overview:
- Write-side counterpart of the game's SDRAM read port.
- Takes the byte stream from the ROM loader (ioctl) during download and turns it into two kinds of output:
  - byte-masked 16-bit SDRAM write requests (prog_*) for the main/char/object ROMs;
  - one-cycle write strobes for the six video PROMs (5n, 7j, 4a, 5b, 5a, 3a).
- Sits between the loader and both the SDRAM controller and jtpopeye_video's PROM write inputs.

Parameters:
- PROM_START, 22'h1_C000, first ioctl byte address mapped to the PROM region; bytes below it go to SDRAM.
- PROM_LEN, 12'h600, total PROM region size in bytes (six 256-byte slots); bytes at or above PROM_START+PROM_LEN are discarded.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- downloading  in  1  loader active
- ioctl_addr  in  22  byte address
- ioctl_data  in  8  byte data
- ioctl_wr  in  1  byte valid, one-cycle pulse
- prog_addr  out  22  SDRAM word address (ioctl_addr>>1)
- prog_data  out  8  byte to write (same byte on both lanes)
- prog_mask  out  2  active-low lane enable; 2'b10 = low byte, 2'b01 = high byte
- prog_we  out  1  SDRAM write request, held until acked
- sdram_ack  in  1  one-cycle acknowledge from the SDRAM controller
- prom_addr  out  8  PROM byte address
- prom_din  out  8  PROM data
- prom_5n_we, prom_7j_we, prom_4a_we, prom_5b_we, prom_5a_we, prom_3a_we  out  1 each  one-cycle PROM write strobes
- dwn_busy  out  1  FIFO not empty or a write is in flight
- dwn_ovf  out  1  sticky overflow flag

Behaviour:
- Reset values: all outputs 0, except prog_mask = 2'b11. Reset clears the FIFO and the state machine, including mid-write; a pending prog_we drops immediately without waiting for ack.
- Input capture:
  - ioctl_wr is accepted only while downloading=1.
  - Each accepted byte pushes {addr, data} into a 2-entry FIFO.
  - Push into a full FIFO: the byte is dropped and dwn_ovf is set to 1. dwn_ovf clears only on reset or on a downloading 0→1 edge.
- Download start: a downloading 0→1 edge clears the FIFO and dwn_ovf.
- Address decode of the FIFO head:
  - addr < PROM_START → SDRAM.
  - PROM_START ≤ addr < PROM_START+PROM_LEN → PROM. Slot = (addr−PROM_START)[10:8]: 0=5n, 1=7j, 2=4a, 3=5b, 4=5a, 5=3a. prom_addr = (addr−PROM_START)[7:0].
  - Otherwise → discard: pop with no side effect.
- State machine (IDLE, SDWR, PROMWR):
  - IDLE, FIFO not empty, SDRAM head → SDWR on the next edge. prog_addr, prog_data and prog_mask are registered from the head; prog_mask follows addr[0] (0 → 2'b10, 1 → 2'b01); prog_we=1.
  - SDWR: hold every prog_* output stable until sdram_ack=1. On the ack cycle, pop the FIFO, set prog_we=0 and prog_mask=2'b11 on the next edge, return to IDLE. Minimum occupancy is 2 cycles per byte.
  - sdram_ack while not in SDWR: ignored.
  - IDLE, PROM head → PROMWR: prom_addr and prom_din are registered and exactly one strobe is high for one cycle; pop, then IDLE. Back-to-back PROM bytes therefore yield one strobe every 2 cycles.
  - IDLE, discard head → pop in one cycle, stay IDLE.
- A push and a pop in the same cycle are both honoured; occupancy is unchanged and this does not count as overflow.
- Writes retire strictly in ioctl order.
- A downloading 1→0 edge does not flush; already-queued bytes still retire.
- dwn_busy = FIFO not empty OR state≠IDLE. It is combinational from registers.

Optional Feature:
- Macro: JTPOPEYE_DWNLD_CHKSUM_EN.
- Defined: adds output port dwn_sum [15:0], reset 0, cleared on a downloading 0→1 edge. It adds each retired byte zero-extended with mod-2^16 wrap; SDRAM and PROM bytes count, discarded and overflowed bytes do not.
- Undefined: the port and its logic are absent. Functional behaviour is otherwise identical.

Test Plan:
- SDRAM byte write:
  - Stimulus: downloading=1; ioctl_wr addr 22'h00_0005, data 8'hA5; sdram_ack 3 cycles after prog_we rises.
  - Required: prog_addr=22'h00_0002, prog_mask=2'b01, prog_data=8'hA5, prog_we high exactly 4 cycles, dwn_busy low 1 cycle after the ack retires.
- PROM decode:
  - Stimulus: bytes at PROM_START+0x000, +0x1FF and +0x5FF with data 11, 22, 33.
  - Required: single-cycle prom_5n_we (addr 00, din 11), then prom_7j_we (FF, 22), then prom_3a_we (FF, 33); no prog_we.
  - Stimulus: a byte at PROM_START+0x600.
  - Required: no strobe of any kind.
- Overflow:
  - Stimulus: hold sdram_ack=0 and push three SDRAM bytes on consecutive cycles.
  - Required: dwn_ovf=1; the third byte never appears on prog_*.
  - Stimulus: toggle downloading 0→1.
  - Required: dwn_ovf=0 and the FIFO is empty.
- Simultaneous push/pop:
  - Stimulus: ioctl_wr coincides with sdram_ack while 1 entry is queued.
  - Required: no overflow; all bytes retire in order.
- Reset mid-write:
  - Stimulus: assert rst_n=0 while prog_we=1.
  - Required: prog_we, dwn_busy and all strobes go to 0 asynchronously; prog_mask=2'b11.
- Checksum (JTPOPEYE_DWNLD_CHKSUM_EN):
  - Stimulus: bytes FF, FF, 02.
  - Required: dwn_sum=16'h0200.
